// File: rtl/bias_pkg.sv
// Shared types for the bias bank loader: bias word type and loader FSM state encoding.
package bias_pkg;

  localparam int BIAS_W = 18;

  typedef logic signed [BIAS_W-1:0] bias_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } bias_ld_state_t;

endpackage

// File: rtl/bias_bank_loader_if.sv
// Serial bias word stream (valid/ready) from the weight/bias fetch unit into the bias bank.
interface bias_bank_loader_if;
  import bias_pkg::*;

  logic  s_valid;
  logic  s_ready;
  bias_t s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/bias_load_ctrl.sv
// Load controller: IDLE/LOAD FSM, lane counter, registered s_ready, load_done pulse, q_valid,
// one-hot per-lane write enables. BIAS_BANK_DBUF_EN keeps q_valid alive while a reload is in flight.
module bias_load_ctrl
  import bias_pkg::*;
#(
  parameter int N_adder_tree = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    load_done,
  output logic                    q_valid,
  output logic [N_adder_tree-1:0] lane_we
);

  localparam int                CNT_W = $clog2(N_adder_tree);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_adder_tree - 1);

  bias_ld_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last_beat;

  // s_ready is high only in LOAD, so a transfer implies LOAD; abort squashes the beat.
  assign xfer      = s_valid & s_ready & ~abort;
  assign last_beat = xfer & (cnt == LAST);

  always_comb begin
    // NOTE: default first so every path assigns lane_we and no latch is inferred.
    lane_we = '0;
    if (xfer) lane_we[cnt] = 1'b1;
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s_ready   <= 1'b0;
      load_done <= 1'b0;
      q_valid   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            cnt     <= '0;
            s_ready <= 1'b1;
`ifndef BIAS_BANK_DBUF_EN
            q_valid <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            s_ready <= 1'b0;
          end else if (last_beat) begin
            state     <= IDLE;
            cnt       <= '0;
            s_ready   <= 1'b0;
            load_done <= 1'b1;
            q_valid   <= 1'b1;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bias_bank_loader.sv
// Loadable bias register bank: serial 18-bit words in (lane 0 first), parallel lane vector out.
// Optional BIAS_BANK_DBUF_EN adds a shadow bank so q switches atomically on the final beat.
module bias_bank_loader
  import bias_pkg::*;
#(
  parameter int N_adder_tree = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  bias_bank_loader_if.slave              s,
  output logic [N_adder_tree*BIAS_W-1:0] q,
  output logic                           q_valid,
  output logic                           load_done
);

  logic [N_adder_tree-1:0] lane_we;
  bias_t                   bank [N_adder_tree];

  bias_load_ctrl #(
    .N_adder_tree (N_adder_tree)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .s_valid   (s.s_valid),
    .s_ready   (s.s_ready),
    .load_done (load_done),
    .q_valid   (q_valid),
    .lane_we   (lane_we)
  );

`ifdef BIAS_BANK_DBUF_EN
  // The last lane never needs a shadow slot: its word goes straight to q on the commit edge.
  bias_t shadow [N_adder_tree-1];

  // NOTE: the shadow is not reset; every slot is rewritten before a commit can expose it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_adder_tree - 1; k++) begin
      if (lane_we[k]) shadow[k] <= s.s_data;
    end
  end

  // Write enable of the last lane fires only on the final beat, so it doubles as the commit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_adder_tree; k++) bank[k] <= '0;
    end else if (lane_we[N_adder_tree-1]) begin
      for (int k = 0; k < N_adder_tree - 1; k++) bank[k] <= shadow[k];
      bank[N_adder_tree-1] <= s.s_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_adder_tree; k++) bank[k] <= '0;
    end else begin
      for (int k = 0; k < N_adder_tree; k++) begin
        if (lane_we[k]) bank[k] <= s.s_data;
      end
    end
  end
`endif

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_pack
    assign q[BIAS_W*k +: BIAS_W] = bank[k];
  end

endmodule

// File: tb/tb_bias_bank_loader.sv
// Scoreboard bench for bias_bank_loader: expected bias sets are queued at stimulus time and
// compared by a monitor whenever load_done fires; directed checks cover reset, abort and rst.
module tb_bias_bank_loader;
  import bias_pkg::*;

  localparam int N  = 16;
  localparam int W  = BIAS_W;
  localparam int QW = N * W;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [QW-1:0] q;
  logic          q_valid;
  logic          load_done;

  bias_bank_loader_if bus ();

  bias_bank_loader #(.N_adder_tree(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .s         (bus.slave),
    .q         (q),
    .q_valid   (q_valid),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  int            total    = 0;
  int            bad      = 0;
  int            done_cnt = 0;
  logic [QW-1:0] sb [$];
  logic [QW-1:0] mon_exp;
  logic [QW-1:0] model_q;

  task automatic check(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [QW-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the bank has taken it (bounded wait).
  task automatic send_word(input logic [W-1:0] d);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.s_ready) check("send_ready_timeout", QW'(bus.s_ready), QW'(1));
    else tick();
    bus.s_valid = 1'b0;
  endtask

  // Monitor: every completed set must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && load_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_load_done", QW'(load_done), QW'(0));
      end else begin
        mon_exp = sb.pop_front();
        check("sb_q", q, mon_exp);
        check("sb_q_valid", QW'(q_valid), QW'(1));
        check("sb_s_ready", QW'(bus.s_ready), QW'(0));
      end
    end
  end

  logic [W-1:0]  w2 [N];
  logic [W-1:0]  w3 [N];
  logic [W-1:0]  w4 [5];
  logic [W-1:0]  w5 [N];
  logic [W-1:0]  w6 [8];
  logic [QW-1:0] exp_v;
  logic [39:0]   pat;
  int            idx;
  int            d0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // 1: reset
    repeat (2) tick();
    check("rst_q", q, '0);
    check("rst_q_valid", QW'(q_valid), QW'(0));
    check("rst_s_ready", QW'(bus.s_ready), QW'(0));
    check("rst_load_done", QW'(load_done), QW'(0));
    rst = 1'b0;
    tick();

    // 2: full load without stalls
    w2[0] = 18'h3FF6C;
    w2[1] = 18'h009B8;
    for (int k = 2; k < N; k++) w2[k] = W'(k);
    for (int k = 0; k < N; k++) exp_v[k*W +: W] = w2[k];
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_ready", QW'(bus.s_ready), QW'(1));
    check("t2_qv_clear", QW'(q_valid), QW'(0));
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) sb.push_back(exp_v);
      send_word(w2[k]);
    end
    check("t2_load_done", QW'(load_done), QW'(1));
    check("t2_q_valid", QW'(q_valid), QW'(1));
    check("t2_lane0", QW'(lane(q, 0)), QW'(18'h3FF6C));
    check("t2_lane1", QW'(lane(q, 1)), QW'(18'h009B8));
    check("t2_s_ready", QW'(bus.s_ready), QW'(0));
    tick();
    check("t2_done_pulse", QW'(load_done), QW'(0));
    model_q = exp_v;

    // 3: stalls from a fixed valid pattern
    for (int k = 0; k < N; k++) w3[k] = 18'h20000 | W'(k << 4);
    for (int k = 0; k < N; k++) exp_v[k*W +: W] = w3[k];
    sb.push_back(exp_v);
    pat   = 40'hA55AF0C399;
    idx   = 0;
    d0    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = pat[39-i];
      bus.s_data  = (idx < N) ? w3[idx] : 18'h3FFFF;
      if (bus.s_valid && bus.s_ready) idx++;
      tick();
    end
    bus.s_valid = 1'b0;
    check("t3_accepted", QW'(idx), QW'(N));
    check("t3_one_done", QW'(done_cnt - d0), QW'(1));
    check("t3_q", q, exp_v);
    model_q = exp_v;

    // 4: abort after five beats; the same-cycle word is dropped
    for (int k = 0; k < 5; k++) w4[k] = 18'h15550 + W'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) send_word(w4[k]);
    abort       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 18'h2AAAA;
    tick();
    abort       = 1'b0;
    bus.s_valid = 1'b0;
    check("t4_s_ready", QW'(bus.s_ready), QW'(0));
    check("t4_no_done", QW'(load_done), QW'(0));
    exp_v = model_q;
`ifdef BIAS_BANK_DBUF_EN
    check("t4_q_valid", QW'(q_valid), QW'(1));
`else
    for (int k = 0; k < 5; k++) exp_v[k*W +: W] = w4[k];
    check("t4_q_valid", QW'(q_valid), QW'(0));
`endif
    check("t4_q", q, exp_v);
    repeat (3) tick();
    check("t4_still_idle", QW'(bus.s_ready), QW'(0));
    model_q = exp_v;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_idle_abort_ready", QW'(bus.s_ready), QW'(0));
    check("t4_idle_abort_q", q, model_q);

    // 5: start and abort together in IDLE start a reload over the existing set
    for (int k = 0; k < N; k++) w5[k] = 18'h3FFFF - W'(k);
    for (int k = 0; k < N; k++) exp_v[k*W +: W] = w5[k];
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_wins", QW'(bus.s_ready), QW'(1));
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) sb.push_back(exp_v);
      send_word(w5[k]);
      if (k < N - 1) begin
`ifdef BIAS_BANK_DBUF_EN
        check("t5_hold_q", q, model_q);
        check("t5_hold_qv", QW'(q_valid), QW'(1));
`else
        check("t5_lane", QW'(lane(q, k)), QW'(w5[k]));
        check("t5_qv_low", QW'(q_valid), QW'(0));
`endif
      end
    end
    check("t5_done", QW'(load_done), QW'(1));
    check("t5_q", q, exp_v);
    model_q = exp_v;
    tick();

    // 6: start held during LOAD is ignored; rst on beat 8 wipes everything
    for (int k = 0; k < 8; k++) w6[k] = 18'h0F0F0 + W'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) send_word(w6[k]);
    start = 1'b1;
    for (int k = 3; k < 7; k++) send_word(w6[k]);
    check("t6_ready", QW'(bus.s_ready), QW'(1));
`ifdef BIAS_BANK_DBUF_EN
    check("t6_q_hold", q, model_q);
`else
    check("t6_lane0", QW'(lane(q, 0)), QW'(w6[0]));
    check("t6_lane6", QW'(lane(q, 6)), QW'(w6[6]));
`endif
    bus.s_valid = 1'b1;
    bus.s_data  = w6[7];
    rst         = 1'b1;
    tick();
    check("t6_rst_q", q, '0);
    check("t6_rst_q_valid", QW'(q_valid), QW'(0));
    check("t6_rst_s_ready", QW'(bus.s_ready), QW'(0));
    check("t6_rst_load_done", QW'(load_done), QW'(0));
    start       = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    check("sb_drained", QW'(sb.size()), QW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
